// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle between fifo_rd_ctrl, the storage array read port and the consumer.
// slave  : the read controller (drives raddr/rptr/status/output register).
// master : the surrounding logic (drives wptr, rdata, dready).
interface fifo_rd_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic [ADDRSIZE:0]   wptr;    // binary write pointer, already in the read clock domain
  logic [ADDRSIZE-1:0] raddr;   // array read address
  logic [DATASIZE-1:0] rdata;   // array read data, combinational from raddr
  logic [ADDRSIZE:0]   rptr;    // read pointer returned to the write side
  logic                rempty;  // array holds no unread words
  logic [ADDRSIZE:0]   rcount;  // unread words in the array, output register excluded
  logic [DATASIZE-1:0] dout;    // output register data
  logic                dvalid;  // dout holds a valid word
  logic                dready;  // consumer accepts dout this cycle

  modport slave (
    input  wptr, rdata, dready,
    output raddr, rptr, rempty, rcount, dout, dvalid
  );

  modport master (
    output wptr, rdata, dready,
    input  raddr, rptr, rempty, rcount, dout, dvalid
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Purpose: FIFO read-side controller; drains the storage array into a one-entry
//          first-word-fall-through output register with a valid/ready handshake.
// Latency: word written at edge N -> rempty falls after N, dvalid rises after N+1.
// Backpressure: while dvalid && !dready, dout/dvalid hold and the pointer stalls;
//          accept and reload in the same cycle give full rate with no bubble.
// Ports: rclk (only clock), rrst (async active-high reset), rd (fifo_rd_ctrl_if.slave):
//          wptr/rdata/dready in; raddr/rptr/rempty/rcount/dout/dvalid out.
// Option: FIFO_RD_GRAY_EN makes rptr a registered Gray pointer for a
//          cross-clock write side; otherwise rptr is the binary read pointer.
module fifo_rd_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input logic           rclk,
  input logic           rrst,
  fifo_rd_ctrl_if.slave rd
);

  localparam logic [ADDRSIZE:0] DEPTH   = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [ADDRSIZE:0] PTR_ONE = {{ADDRSIZE{1'b0}}, 1'b1};

  logic [ADDRSIZE:0]   rbin_q, rbin_d;
  logic [DATASIZE-1:0] dout_q, dout_d;
  logic                dvalid_q, dvalid_d;
  logic [ADDRSIZE:0]   rbin_nxt;
  logic                rempty;
  logic                load;
  logic                accept;

  // Empty is judged against the synchronised wptr, so a word is only loaded
  // once the write side has published it; stale array data is never taken.
  assign rempty   = (rd.wptr == rbin_q);
  assign accept   = dvalid_q && rd.dready;
  // Load when the output register is free or is being emptied this cycle.
  assign load     = !rempty && (!dvalid_q || rd.dready);
  assign rbin_nxt = rbin_q + PTR_ONE;

  always_comb begin
    rbin_d   = rbin_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    if (load) begin
      dout_d   = rd.rdata;
      dvalid_d = 1'b1;
      rbin_d   = rbin_nxt;
    end else if (accept) begin
      dvalid_d = 1'b0;  // dout keeps its last value
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q   <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

`ifdef FIFO_RD_GRAY_EN
  // Gray copy registered alongside rbin so the pointer leaving this domain
  // never shows more than one changing bit.
  logic [ADDRSIZE:0] rptr_q, rptr_d;

  always_comb begin
    rptr_d = rptr_q;
    if (load) begin
      rptr_d = rbin_nxt ^ (rbin_nxt >> 1);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
    end
  end

  assign rd.rptr = rptr_q;
`else
  assign rd.rptr = rbin_q;
`endif

  assign rd.raddr  = rbin_q[ADDRSIZE-1:0];
  assign rd.rempty = rempty;
  assign rd.rcount = rd.wptr - rbin_q;  // modulo 2^(ADDRSIZE+1)
  assign rd.dout   = dout_q;
  assign rd.dvalid = dvalid_q;

`ifndef SYNTHESIS
  // The write side must never hold more than DEPTH unread words.
  a_no_overfill: assert property (@(posedge rclk) disable iff (rrst) rd.rcount <= DEPTH);
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl. The reference model keeps the unread
// array contents as a queue plus a one-entry output slot, and derives the
// expected read pointer from the number of words loaded so far.
module tb_fifo_rd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic rclk;
  logic rrst;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  fifo_rd_ctrl_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  fifo_rd_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .rd   (bus)
  );

  assign bus.rdata = mem[bus.raddr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // reference model state
  logic [DW-1:0] mq[$];     // words written but not yet loaded
  bit            ov;        // output slot holds a word
  logic [DW-1:0] od;        // output slot data
  int unsigned   nload;     // words loaded since reset
  logic [AW:0]   prev_rptr;

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW:0] exp_rptr(input int unsigned n);
    logic [AW:0] b;
    b = n[AW:0];
`ifdef FIFO_RD_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    ov = 0;
    od = '0;
    nload = 0;
    prev_rptr = '0;
  endtask

  // Called at posedge+1: optionally write one word, drive dready, check the
  // pre-edge status, step the clock, then check the registered outputs.
  task automatic cycle(input bit wr, input logic [DW-1:0] wd, input bit rdy);
    bit acc, ld;
    if (wr && mq.size() < (1 << AW)) begin
      mem[bus.wptr[AW-1:0]] = wd;
      bus.wptr = bus.wptr + 1'b1;
      mq.push_back(wd);
    end
    bus.dready = rdy;
    #1;
    chk("rempty", 32'(bus.rempty), 32'(mq.size() == 0));
    chk("rcount", 32'(bus.rcount), 32'(mq.size()));
    acc = ov && rdy;
    ld  = (mq.size() != 0) && (!ov || rdy);
    @(posedge rclk);
    if (ld) begin
      od = mq.pop_front();
      ov = 1;
      nload++;
    end else if (acc) begin
      ov = 0;
    end
    #1;
    chk("dvalid", 32'(bus.dvalid), 32'(ov));
    chk("dout",   32'(bus.dout),   32'(od));
    chk("rptr",   32'(bus.rptr),   32'(exp_rptr(nload)));
`ifdef FIFO_RD_GRAY_EN
    chk("rptr_1bit", 32'($countones(bus.rptr ^ prev_rptr) <= 1), 32'd1);
`endif
    prev_rptr = bus.rptr;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // reset
    rrst = 1'b1;
    bus.wptr = '0;
    bus.dready = 1'b0;
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_dvalid", 32'(bus.dvalid), 32'd0);
    chk("rst_dout",   32'(bus.dout),   32'd0);
    chk("rst_rptr",   32'(bus.rptr),   32'd0);
    chk("rst_raddr",  32'(bus.raddr),  32'd0);
    chk("rst_rempty", 32'(bus.rempty), 32'd1);
    chk("rst_rcount", 32'(bus.rcount), 32'd0);
    rrst = 1'b0;

    // single word, held under backpressure, then accepted
    cycle(1'b1, 8'hA5, 1'b0);
    chk("single_dout", 32'(bus.dout), 32'hA5);
    chk("single_rempty", 32'(bus.rempty), 32'd1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("single_hold", 32'(bus.dout), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1);
    chk("single_drained", 32'(bus.dvalid), 32'd0);

    // streaming: fill 16 words, then drain at full rate
    for (int i = 0; i < 16; i++) begin
      mem[bus.wptr[AW-1:0]] = 8'(i);
      bus.wptr = bus.wptr + 1'b1;
      mq.push_back(8'(i));
    end
    for (int i = 0; i < 17; i++) cycle(1'b0, 8'h00, 1'b1);

    // backpressure pattern 1,0,0,1 while streaming
    for (int i = 0; i < 24; i++) cycle(i < 12, 8'($urandom), (i % 4 == 0) || (i % 4 == 3));
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

    // push/pop 40 words so the pointer wraps
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom),
            (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1);

    // reset mid-operation with dvalid=1 and rcount=5
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("pre_rst_dvalid", 32'(bus.dvalid), 32'd1);
    chk("pre_rst_rcount", 32'(bus.rcount), 32'd5);
    #2;
    rrst = 1'b1;
    #1;
    chk("async_dvalid", 32'(bus.dvalid), 32'd0);
    chk("async_rptr",   32'(bus.rptr),   32'd0);
    chk("async_raddr",  32'(bus.raddr),  32'd0);
    chk("async_rbin",   32'(bus.rcount), 32'(bus.wptr));
    chk("async_dout",   32'(bus.dout),   32'd0);
    bus.wptr = '0;
    model_reset();
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
